// File: rtl/riscv_pkg.sv
// Shared types for the iBus/dBus arbiter: request source tags and access sizes.
// Pure definitions; no timing or flow control of its own.
package riscv_pkg;

   typedef enum logic {SRC_IBUS, SRC_DBUS} bus_src_e;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} access_size_e;

   // A command expects a response unless it is a dBus store.
   function automatic logic is_read(input bus_src_e src, input logic wr);
      return (src == SRC_IBUS) || !wr;
   endfunction

endpackage

// File: rtl/riscv_src_fifo.sv
// 1-bit source FIFO: push/pop take effect on the clock edge, head is combinational (0-cycle read).
// A push into a full FIFO is taken only when a pop happens in the same cycle; a pop of an empty FIFO is ignored.
module riscv_src_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rstf,
   input  logic push,
   input  logic push_dat,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [DEPTH-1:0] store;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB tells full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = store[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         store  <= '0;
      end else begin
         if (do_push) begin
            store[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr                <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/riscv_bus_arbiter.sv
// Shares one memory port between iBus and dBus; commands pass combinationally, responses return 1 cycle after mem_rsp_valid.
// A stalled command is locked until mem_cmd_ready; reads stall while MAX_OUTSTANDING are in flight.
module riscv_bus_arbiter
   import riscv_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 3,
   parameter int ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              rstf,
   input  logic              iBus_cmd_valid,
   output logic              iBus_cmd_ready,
   input  logic [ADDR_W-1:0] iBus_cmd_payload_pc,
   output logic              iBus_rsp_ready,
   output logic              iBus_rsp_err,
   output logic [31:0]       iBus_rsp_inst,
   input  logic              dBus_cmd_valid,
   output logic              dBus_cmd_ready,
   input  logic              dBus_cmd_payload_wr,
   input  logic [ADDR_W-1:0] dBus_cmd_payload_address,
   input  logic [31:0]       dBus_cmd_payload_data,
   input  logic [1:0]        dBus_cmd_payload_size,
   output logic              dBus_rsp_ready,
   output logic              dBus_rsp_err,
   output logic [31:0]       dBus_rsp_data,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_payload_wr,
   output logic [ADDR_W-1:0] mem_cmd_payload_address,
   output logic [31:0]       mem_cmd_payload_data,
   output logic [1:0]        mem_cmd_payload_size,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_data,
   input  logic              mem_rsp_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic          lock_vld;
   bus_src_e      lock_src;
   logic [SW-1:0] starve_cnt;

   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_head;

   logic          rsp_pop;
   logic          can_read;
   logic          i_elig;
   logic          d_elig;
   logic          gnt_vld;
   bus_src_e      gnt_src;
   logic          cmd_hs;
   logic          fifo_push;

   // A full FIFO still takes a read when a response frees a slot this cycle.
   assign rsp_pop  = mem_rsp_valid && !fifo_empty;
   assign can_read = !fifo_full || rsp_pop;
   assign i_elig   = iBus_cmd_valid && can_read;
   assign d_elig   = dBus_cmd_valid && (dBus_cmd_payload_wr || can_read);

   always_comb begin
      gnt_vld = 1'b0;
      gnt_src = SRC_DBUS;
      if (lock_vld) begin
         gnt_vld = 1'b1;
         gnt_src = lock_src;
      end else if (i_elig && (starve_cnt == SW'(STARVE_LIMIT))) begin
         gnt_vld = 1'b1;
         gnt_src = SRC_IBUS;
      end else if (d_elig) begin
         gnt_vld = 1'b1;
         gnt_src = SRC_DBUS;
      end else if (i_elig) begin
         gnt_vld = 1'b1;
         gnt_src = SRC_IBUS;
      end
   end

   assign mem_cmd_valid  = rstf && gnt_vld;
   assign cmd_hs         = mem_cmd_valid && mem_cmd_ready;
   assign iBus_cmd_ready = cmd_hs && (gnt_src == SRC_IBUS);
   assign dBus_cmd_ready = cmd_hs && (gnt_src == SRC_DBUS);
   assign fifo_push      = cmd_hs && is_read(gnt_src, dBus_cmd_payload_wr);

   // Payload is forced to zero while reset is held so nothing leaks to memory.
   always_comb begin
      mem_cmd_payload_wr      = 1'b0;
      mem_cmd_payload_address = '0;
      mem_cmd_payload_data    = '0;
      mem_cmd_payload_size    = '0;
      if (rstf) begin
         if (gnt_src == SRC_IBUS) begin
            mem_cmd_payload_address = iBus_cmd_payload_pc;
            mem_cmd_payload_size    = SZ_W;
         end else begin
            mem_cmd_payload_wr      = dBus_cmd_payload_wr;
            mem_cmd_payload_address = dBus_cmd_payload_address;
            mem_cmd_payload_data    = dBus_cmd_payload_data;
            mem_cmd_payload_size    = dBus_cmd_payload_size;
         end
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         lock_vld <= 1'b0;
         lock_src <= SRC_IBUS;
      end else begin
         lock_vld <= mem_cmd_valid && !mem_cmd_ready;
         lock_src <= gnt_src;
      end
   end

   // Counts dBus wins while iBus waits; saturates so the forced iBus grant persists until taken.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         starve_cnt <= '0;
      end else if (!iBus_cmd_valid) begin
         starve_cnt <= '0;
      end else if (cmd_hs && (gnt_src == SRC_IBUS)) begin
         starve_cnt <= '0;
      end else if (cmd_hs && (starve_cnt != SW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   riscv_src_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_src_fifo (
      .clk      (clk),
      .rstf     (rstf),
      .push     (fifo_push),
      .push_dat (gnt_src == SRC_DBUS),
      .pop      (rsp_pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         iBus_rsp_ready <= 1'b0;
         iBus_rsp_err   <= 1'b0;
         iBus_rsp_inst  <= '0;
         dBus_rsp_ready <= 1'b0;
         dBus_rsp_err   <= 1'b0;
         dBus_rsp_data  <= '0;
      end else begin
         iBus_rsp_ready <= rsp_pop && !fifo_head;
         dBus_rsp_ready <= rsp_pop && fifo_head;
         if (rsp_pop && !fifo_head) begin
            iBus_rsp_inst <= mem_rsp_data;
            iBus_rsp_err  <= mem_rsp_err;
         end
         if (rsp_pop && fifo_head) begin
            dBus_rsp_data <= mem_rsp_data;
            dBus_rsp_err  <= mem_rsp_err;
         end
      end
   end

   // Simulation-only: a response with nothing outstanding is dropped by the logic above.
   rsp_without_read: assert property (@(posedge clk) disable iff (!rstf)
      !(mem_rsp_valid && fifo_empty));

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Directed bench for riscv_bus_arbiter: arbitration order, stall lock, outstanding limit, routing, async reset.
module tb_riscv_bus_arbiter;

   logic        clk;
   logic        rstf;
   logic        iBus_cmd_valid;
   logic        iBus_cmd_ready;
   logic [31:0] iBus_cmd_payload_pc;
   logic        iBus_rsp_ready;
   logic        iBus_rsp_err;
   logic [31:0] iBus_rsp_inst;
   logic        dBus_cmd_valid;
   logic        dBus_cmd_ready;
   logic        dBus_cmd_payload_wr;
   logic [31:0] dBus_cmd_payload_address;
   logic [31:0] dBus_cmd_payload_data;
   logic [1:0]  dBus_cmd_payload_size;
   logic        dBus_rsp_ready;
   logic        dBus_rsp_err;
   logic [31:0] dBus_rsp_data;
   logic        mem_cmd_valid;
   logic        mem_cmd_ready;
   logic        mem_cmd_payload_wr;
   logic [31:0] mem_cmd_payload_address;
   logic [31:0] mem_cmd_payload_data;
   logic [1:0]  mem_cmd_payload_size;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;

   int checks;
   int errors;

   riscv_bus_arbiter #(
      .MAX_OUTSTANDING (4),
      .STARVE_LIMIT    (3),
      .ADDR_W          (32)
   ) u_dut (
      .clk                      (clk),
      .rstf                     (rstf),
      .iBus_cmd_valid           (iBus_cmd_valid),
      .iBus_cmd_ready           (iBus_cmd_ready),
      .iBus_cmd_payload_pc      (iBus_cmd_payload_pc),
      .iBus_rsp_ready           (iBus_rsp_ready),
      .iBus_rsp_err             (iBus_rsp_err),
      .iBus_rsp_inst            (iBus_rsp_inst),
      .dBus_cmd_valid           (dBus_cmd_valid),
      .dBus_cmd_ready           (dBus_cmd_ready),
      .dBus_cmd_payload_wr      (dBus_cmd_payload_wr),
      .dBus_cmd_payload_address (dBus_cmd_payload_address),
      .dBus_cmd_payload_data    (dBus_cmd_payload_data),
      .dBus_cmd_payload_size    (dBus_cmd_payload_size),
      .dBus_rsp_ready           (dBus_rsp_ready),
      .dBus_rsp_err             (dBus_rsp_err),
      .dBus_rsp_data            (dBus_rsp_data),
      .mem_cmd_valid            (mem_cmd_valid),
      .mem_cmd_ready            (mem_cmd_ready),
      .mem_cmd_payload_wr       (mem_cmd_payload_wr),
      .mem_cmd_payload_address  (mem_cmd_payload_address),
      .mem_cmd_payload_data     (mem_cmd_payload_data),
      .mem_cmd_payload_size     (mem_cmd_payload_size),
      .mem_rsp_valid            (mem_rsp_valid),
      .mem_rsp_data             (mem_rsp_data),
      .mem_rsp_err              (mem_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iBus_cmd_valid           = 1'b0;
      iBus_cmd_payload_pc      = '0;
      dBus_cmd_valid           = 1'b0;
      dBus_cmd_payload_wr      = 1'b0;
      dBus_cmd_payload_address = '0;
      dBus_cmd_payload_data    = '0;
      dBus_cmd_payload_size    = 2'd2;
      mem_cmd_ready            = 1'b1;
      mem_rsp_valid            = 1'b0;
      mem_rsp_data             = '0;
      mem_rsp_err              = 1'b0;
   endtask

   initial begin
      logic [1:0]  gnt_seq [8];
      logic [31:0] rsp_vals [4];

      checks = 0;
      errors = 0;
      gnt_seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
      rsp_vals = '{32'h61, 32'h62, 32'h63, 32'h64};

      // Reset with live requests on the inputs: every output must stay 0.
      idle();
      rstf                     = 1'b0;
      iBus_cmd_valid           = 1'b1;
      iBus_cmd_payload_pc      = 32'h123;
      dBus_cmd_valid           = 1'b1;
      dBus_cmd_payload_wr      = 1'b1;
      dBus_cmd_payload_data    = 32'h55;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mem_vld",  {31'd0, mem_cmd_valid}, 32'd0);
      chk("rst_i_rdy",    {31'd0, iBus_cmd_ready}, 32'd0);
      chk("rst_d_rdy",    {31'd0, dBus_cmd_ready}, 32'd0);
      chk("rst_addr",     mem_cmd_payload_address, 32'd0);
      chk("rst_data",     mem_cmd_payload_data, 32'd0);
      chk("rst_i_rsp",    {31'd0, iBus_rsp_ready}, 32'd0);
      tick();
      idle();
      tick();
      rstf = 1'b1;

      // 1: single fetch, response two cycles after the command.
      tick();
      iBus_cmd_valid      = 1'b1;
      iBus_cmd_payload_pc = 32'h1000;
      @(negedge clk);
      chk("t1_mem_vld", {31'd0, mem_cmd_valid}, 32'd1);
      chk("t1_addr",    mem_cmd_payload_address, 32'h1000);
      chk("t1_wr",      {31'd0, mem_cmd_payload_wr}, 32'd0);
      chk("t1_size",    {30'd0, mem_cmd_payload_size}, 32'd2);
      chk("t1_i_rdy",   {31'd0, iBus_cmd_ready}, 32'd1);
      tick();
      iBus_cmd_valid = 1'b0;
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h00000013;
      @(negedge clk);
      chk("t1_rsp_early", {31'd0, iBus_rsp_ready}, 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("t1_rsp_rdy",  {31'd0, iBus_rsp_ready}, 32'd1);
      chk("t1_rsp_inst", iBus_rsp_inst, 32'h00000013);
      chk("t1_rsp_err",  {31'd0, iBus_rsp_err}, 32'd0);
      chk("t1_d_rsp",    {31'd0, dBus_rsp_ready}, 32'd0);
      tick();
      @(negedge clk);
      chk("t1_rsp_pulse", {31'd0, iBus_rsp_ready}, 32'd0);

      // 2: both buses request every cycle; dBus stores so only fetches occupy the FIFO.
      tick();
      iBus_cmd_valid           = 1'b1;
      iBus_cmd_payload_pc      = 32'h2000;
      dBus_cmd_valid           = 1'b1;
      dBus_cmd_payload_wr      = 1'b1;
      dBus_cmd_payload_address = 32'h8000;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("t2_gnt%0d", k), {30'd0, iBus_cmd_ready, dBus_cmd_ready}, {30'd0, gnt_seq[k]});
         tick();
      end
      idle();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hA1;
      tick();
      mem_rsp_data  = 32'hA2;
      @(negedge clk);
      chk("t2_rsp0", iBus_rsp_inst, 32'hA1);
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("t2_rsp1", iBus_rsp_inst, 32'hA2);

      // 3: store stalled for five cycles with a fetch also waiting.
      tick();
      mem_cmd_ready            = 1'b0;
      iBus_cmd_valid           = 1'b1;
      iBus_cmd_payload_pc      = 32'h3000;
      dBus_cmd_valid           = 1'b1;
      dBus_cmd_payload_wr      = 1'b1;
      dBus_cmd_payload_address = 32'h2000;
      dBus_cmd_payload_data    = 32'hDEADBEEF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("t3_addr%0d", k), mem_cmd_payload_address, 32'h2000);
         chk($sformatf("t3_data%0d", k), mem_cmd_payload_data, 32'hDEADBEEF);
         chk($sformatf("t3_wr%0d", k),   {31'd0, mem_cmd_payload_wr}, 32'd1);
         chk($sformatf("t3_rdy%0d", k),  {30'd0, iBus_cmd_ready, dBus_cmd_ready}, 32'd0);
         tick();
      end
      mem_cmd_ready = 1'b1;
      @(negedge clk);
      chk("t3_d_rdy", {30'd0, iBus_cmd_ready, dBus_cmd_ready}, 32'd1);
      tick();
      idle();
      @(negedge clk);
      chk("t3_no_rsp", {30'd0, iBus_rsp_ready, dBus_rsp_ready}, 32'd0);

      // 4: four loads fill the FIFO (the earlier store must not have taken a slot).
      for (int k = 0; k < 4; k++) begin
         tick();
         dBus_cmd_valid           = 1'b1;
         dBus_cmd_payload_wr      = 1'b0;
         dBus_cmd_payload_address = 32'h100 + 32'(4 * k);
         @(negedge clk);
         chk($sformatf("t4_ld%0d", k), {31'd0, dBus_cmd_ready}, 32'd1);
      end
      tick();
      iBus_cmd_valid           = 1'b1;
      iBus_cmd_payload_pc      = 32'h4000;
      dBus_cmd_payload_wr      = 1'b1;
      dBus_cmd_payload_address = 32'h500;
      @(negedge clk);
      chk("t4_st_rdy",   {31'd0, dBus_cmd_ready}, 32'd1);
      chk("t4_i_block",  {31'd0, iBus_cmd_ready}, 32'd0);
      tick();
      dBus_cmd_valid = 1'b0;
      @(negedge clk);
      chk("t4_full_vld", {31'd0, mem_cmd_valid}, 32'd0);
      chk("t4_full_rdy", {31'd0, iBus_cmd_ready}, 32'd0);
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h55;
      @(negedge clk);
      chk("t4_swap_rdy", {31'd0, iBus_cmd_ready}, 32'd1);
      tick();
      mem_rsp_valid            = 1'b0;
      iBus_cmd_valid           = 1'b0;
      dBus_cmd_valid           = 1'b1;
      dBus_cmd_payload_wr      = 1'b0;
      dBus_cmd_payload_address = 32'h600;
      @(negedge clk);
      chk("t4_still_full", {31'd0, dBus_cmd_ready}, 32'd0);
      chk("t4_rsp_rdy",    {31'd0, dBus_rsp_ready}, 32'd1);
      chk("t4_rsp_data",   dBus_rsp_data, 32'h55);
      tick();
      idle();
      for (int k = 0; k < 4; k++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = rsp_vals[k];
         tick();
         mem_rsp_valid = 1'b0;
         @(negedge clk);
         if (k < 3) begin
            chk($sformatf("t4_drain%0d", k), dBus_rsp_data, rsp_vals[k]);
            chk($sformatf("t4_drain_rdy%0d", k), {30'd0, iBus_rsp_ready, dBus_rsp_ready}, 32'd1);
         end else begin
            chk("t4_drain_i", iBus_rsp_inst, rsp_vals[k]);
            chk("t4_drain_i_rdy", {30'd0, iBus_rsp_ready, dBus_rsp_ready}, 32'd2);
         end
      end

      // 5: reads I, D, I; the middle (dBus) response carries an error.
      tick();
      iBus_cmd_valid      = 1'b1;
      iBus_cmd_payload_pc = 32'h10;
      tick();
      iBus_cmd_valid           = 1'b0;
      dBus_cmd_valid           = 1'b1;
      dBus_cmd_payload_wr      = 1'b0;
      dBus_cmd_payload_address = 32'h20;
      tick();
      dBus_cmd_valid      = 1'b0;
      iBus_cmd_valid      = 1'b1;
      iBus_cmd_payload_pc = 32'h14;
      tick();
      idle();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h111;
      tick();
      mem_rsp_data  = 32'h222;
      mem_rsp_err   = 1'b1;
      @(negedge clk);
      chk("t5_r0_rdy",  {30'd0, iBus_rsp_ready, dBus_rsp_ready}, 32'd2);
      chk("t5_r0_inst", iBus_rsp_inst, 32'h111);
      chk("t5_r0_err",  {31'd0, iBus_rsp_err}, 32'd0);
      tick();
      mem_rsp_data = 32'h333;
      mem_rsp_err  = 1'b0;
      @(negedge clk);
      chk("t5_r1_rdy",  {30'd0, iBus_rsp_ready, dBus_rsp_ready}, 32'd1);
      chk("t5_r1_data", dBus_rsp_data, 32'h222);
      chk("t5_r1_err",  {31'd0, dBus_rsp_err}, 32'd1);
      chk("t5_r1_hold", iBus_rsp_inst, 32'h111);
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("t5_r2_rdy",  {30'd0, iBus_rsp_ready, dBus_rsp_ready}, 32'd2);
      chk("t5_r2_inst", iBus_rsp_inst, 32'h333);
      chk("t5_r2_err",  {31'd0, iBus_rsp_err}, 32'd0);
      chk("t5_r2_hold", dBus_rsp_data, 32'h222);

      // 6: asynchronous reset with two fetches outstanding and a stalled store on the port.
      tick();
      iBus_cmd_valid      = 1'b1;
      iBus_cmd_payload_pc = 32'h40;
      tick();
      iBus_cmd_payload_pc = 32'h44;
      tick();
      iBus_cmd_valid           = 1'b0;
      dBus_cmd_valid           = 1'b1;
      dBus_cmd_payload_wr      = 1'b1;
      dBus_cmd_payload_address = 32'h700;
      dBus_cmd_payload_data    = 32'h77;
      mem_cmd_ready            = 1'b0;
      @(negedge clk);
      chk("t6_pre_vld", {31'd0, mem_cmd_valid}, 32'd1);
      #1;
      rstf = 1'b0;
      #1;
      chk("t6_vld",    {31'd0, mem_cmd_valid}, 32'd0);
      chk("t6_addr",   mem_cmd_payload_address, 32'd0);
      chk("t6_data",   mem_cmd_payload_data, 32'd0);
      chk("t6_wr",     {31'd0, mem_cmd_payload_wr}, 32'd0);
      chk("t6_i_inst", iBus_rsp_inst, 32'd0);
      chk("t6_d_data", dBus_rsp_data, 32'd0);
      chk("t6_d_err",  {31'd0, dBus_rsp_err}, 32'd0);
      tick();
      idle();
      tick();
      rstf = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         dBus_cmd_valid           = 1'b1;
         dBus_cmd_payload_wr      = 1'b0;
         dBus_cmd_payload_address = 32'h900 + 32'(4 * k);
         @(negedge clk);
         chk($sformatf("t6_post_ld%0d", k), {31'd0, dBus_cmd_ready}, (k < 4) ? 32'd1 : 32'd0);
      end
      tick();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
